// File: rtl/ac_ctrl_pkg.sv
// Shared state encoding for the lab's control FSMs.
package ac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  localparam int CTRL_STATE_W = 2;

endpackage

// File: rtl/iter_down_counter_core.sv
// WIDTH-bit count register with synchronous clear, load and decrement.
// Precedence: clr > ld > dec.
module down_counter_core #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  // Count register; the FSM never requests dec at zero, so no wrap guard.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= INITIAL_VALUE;
    end else if (clr) begin
      q <= INITIAL_VALUE;
    end else if (ld) begin
      q <= ld_val;
    end else if (dec) begin
      q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/iter_down_counter.sv
// Iteration down-counter with start/done handshake and optional auto-reload.
//
// state | meaning
// IDLE  | waiting for start; q holds last value
// RUN   | counting down on c_dn; busy high
// DONE  | terminal count reached; done high for this one cycle
module iter_down_counter
  import ac_ctrl_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             c_dn,
  input  logic             clr,
  input  logic             rld,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [WIDTH-1:0] rld_reg;
  logic             core_ld;
  logic [WIDTH-1:0] core_ld_val;
  logic             core_dec;
  logic             rld_cap;

  // Next-state and counter-control decode; clr overrides every state action.
  always_comb begin
    state_nxt   = state;
    core_ld     = 1'b0;
    core_ld_val = ld_val;
    core_dec    = 1'b0;
    rld_cap     = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            core_ld   = 1'b1;
            rld_cap   = 1'b1;
            state_nxt = (ld_val != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (c_dn) begin
            core_dec = 1'b1;
            if (q == WIDTH'(1)) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (rld && (rld_reg != '0)) begin
            core_ld     = 1'b1;
            core_ld_val = rld_reg;
            state_nxt   = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register with busy/done registered straight from the next state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Reload value remembered from the most recent accepted start.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rld_reg <= '0;
    end else if (rld_cap) begin
      rld_reg <= ld_val;
    end
  end

  down_counter_core #(
    .WIDTH         (WIDTH),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_core (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (clr),
    .ld     (core_ld),
    .ld_val (core_ld_val),
    .dec    (core_dec),
    .q      (q)
  );

  assign zero = (q == '0);

endmodule

// File: tb/tb_iter_down_counter.sv
// Directed bench for iter_down_counter with INITIAL_VALUE = 8'hFF.
module tb_iter_down_counter;

  localparam int         W    = 8;
  localparam logic [7:0] INIT = 8'hFF;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         start;
  logic [W-1:0] ld_val;
  logic         c_dn;
  logic         clr;
  logic         rld;
  logic [W-1:0] q;
  logic         zero;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  iter_down_counter #(.WIDTH(W), .INITIAL_VALUE(INIT)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .ld_val (ld_val),
    .c_dn   (c_dn),
    .clr    (clr),
    .rld    (rld),
    .q      (q),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed only after this.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; start = 1'b0; ld_val = '0; c_dn = 1'b0; clr = 1'b0; rld = 1'b0;
    #12;
    n_checks++; if (q !== INIT) begin n_fail++; $display("FAIL reset_q got %h exp %h", q, INIT); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b exp 0", zero); end
    @(negedge clk); rst_b = 1'b1;
    tick();
    n_checks++; if (q !== INIT || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset q %h busy %b exp %h 0", q, busy, INIT); end
  endtask

  task automatic test_count3();
    logic [7:0] exp_q    [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
    logic       exp_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    start = 1'b1; ld_val = 8'd3; c_dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      n_checks++;
      if (q !== exp_q[i] || busy !== exp_busy[i] || done !== exp_done[i]) begin
        n_fail++;
        $display("FAIL count3[%0d] q %h busy %b done %b exp %h %b %b", i, q, busy, done, exp_q[i], exp_busy[i], exp_done[i]);
      end
    end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL count3_zero got %b exp 1", zero); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || q !== 8'd0) begin n_fail++; $display("FAIL count3_idle q %h busy %b done %b exp 00 0 0", q, busy, done); end
    c_dn = 1'b0;
  endtask

  task automatic test_zero_count();
    start = 1'b1; ld_val = 8'd0;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'd0) begin n_fail++; $display("FAIL zero_start q %h busy %b done %b exp 00 0 1", q, busy, done); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_after busy %b done %b exp 0 0", busy, done); end
  endtask

  task automatic test_gapped();
    logic       en    [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp_q [6] = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd0};
    start = 1'b1; ld_val = 8'd4; c_dn = 1'b0;
    tick();
    start = 1'b0;
    n_checks++; if (q !== 8'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_load q %h busy %b exp 04 1", q, busy); end
    for (int i = 0; i < 6; i++) begin
      c_dn = en[i];
      start = (i == 1);
      ld_val = 8'd9;
      tick();
      n_checks++;
      if (q !== exp_q[i] || done !== (i == 5) || busy !== (i != 5)) begin
        n_fail++;
        $display("FAIL gap[%0d] q %h busy %b done %b exp %h %b %b", i, q, busy, done, exp_q[i], i != 5, i == 5);
      end
    end
    start = 1'b0; c_dn = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL gap_idle busy %b done %b exp 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q    [6] = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0};
    logic       exp_done [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    start = 1'b1; ld_val = 8'd2; c_dn = 1'b1; rld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start = 1'b0;
      n_checks++;
      if (q !== exp_q[i] || done !== exp_done[i] || busy !== !exp_done[i]) begin
        n_fail++;
        $display("FAIL reload[%0d] q %h busy %b done %b exp %h %b %b", i, q, busy, done, exp_q[i], !exp_done[i], exp_done[i]);
      end
    end
    rld = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || q !== 8'd0) begin n_fail++; $display("FAIL reload_stop q %h busy %b done %b exp 00 0 0", q, busy, done); end
    c_dn = 1'b0;
  endtask

  task automatic test_clr();
    start = 1'b1; ld_val = 8'd7; c_dn = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_checks++; if (q !== 8'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL clr_pre q %h busy %b exp 05 1", q, busy); end
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    n_checks++; if (q !== INIT || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL clr_q q %h busy %b done %b exp %h 0 0", q, busy, done, INIT); end
    tick();
    n_checks++; if (q !== INIT || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_after q %h busy %b done %b exp %h 0 0", q, busy, done, INIT); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; ld_val = 8'd7; c_dn = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++; if (q !== 8'd6) begin n_fail++; $display("FAIL arst_pre q %h exp 06", q); end
    #2 rst_b = 1'b0;
    #1;
    n_checks++; if (q !== INIT || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_async q %h busy %b done %b exp %h 0 0", q, busy, done, INIT); end
    @(negedge clk); rst_b = 1'b1;
    tick(); tick();
    n_checks++; if (q !== INIT || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_noresume q %h busy %b done %b exp %h 0 0", q, busy, done, INIT); end
    c_dn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count3();
    test_zero_count();
    test_gapped();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
